// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings, grid geometry and init values for the snake game
package snake_pkg;

    typedef enum logic [1:0] {
        ST_RUNNING = 2'b00,
        ST_DIE     = 2'b01,
        ST_INITIAL = 2'b10
    } game_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam int GRID_W    = 32;
    localparam int GRID_H    = 24;
    localparam int MAX_LEN   = 63;
    localparam int NUM_SEGS  = 64;
    localparam int COORD_W   = 5;
    localparam int CELL_SIZE = 20;

    localparam logic [4:0] INIT_HEAD_X  = 5'd16;
    localparam logic [4:0] INIT_HEAD_Y  = 5'd12;
    localparam logic [4:0] INIT_APPLE_X = 5'd24;
    localparam logic [4:0] INIT_APPLE_Y = 5'd12;
    localparam logic [5:0] INIT_LEN     = 6'd3;

    // Segment 0 sits in the low bits, so the head is the last field of the concatenation.
    localparam logic [NUM_SEGS*COORD_W-1:0] INIT_SEG_X =
        {{(NUM_SEGS-3){5'd0}}, INIT_HEAD_X - 5'd2, INIT_HEAD_X - 5'd1, INIT_HEAD_X};
    localparam logic [NUM_SEGS*COORD_W-1:0] INIT_SEG_Y =
        {{(NUM_SEGS-3){5'd0}}, INIT_HEAD_Y, INIT_HEAD_Y, INIT_HEAD_Y};

    // UP/DOWN and RIGHT/LEFT differ only in bit 0.
    function automatic logic is_reverse(logic [1:0] a, logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_game_core_if.sv
// rtl/snake_game_core_if.sv - player controls in, renderer-facing game view out
interface snake_game_core_if;
    import snake_pkg::*;

    logic                          start;
    logic [1:0]                    dir_in;
    logic                          dir_valid;
    logic [NUM_SEGS*COORD_W-1:0]   snake_x_1dim;
    logic [NUM_SEGS*COORD_W-1:0]   snake_y_1dim;
    logic [5:0]                    snake_length;
    logic [4:0]                    apple_x;
    logic [4:0]                    apple_y;
    logic [1:0]                    game_state;

    modport master (
        output start, dir_in, dir_valid,
        input  snake_x_1dim, snake_y_1dim, snake_length, apple_x, apple_y, game_state
    );

    modport slave (
        input  start, dir_in, dir_valid,
        output snake_x_1dim, snake_y_1dim, snake_length, apple_x, apple_y, game_state
    );

endinterface

// File: rtl/apple_lfsr.sv
// rtl/apple_lfsr.sv - free-running x^10+x^7+1 LFSR folded into an on-grid apple candidate
module apple_lfsr
    import snake_pkg::*;
#(
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic       clk,
    input  logic       clrn,
    output logic [4:0] cand_x,
    output logic [4:0] cand_y
);

    logic [9:0] lfsr;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    // Rows 24..31 fold onto 16..23 so every candidate lands on the grid.
    assign cand_x = lfsr[4:0];
    assign cand_y = (lfsr[9:5] >= 5'(GRID_H)) ? (lfsr[9:5] - 5'(GRID_W - GRID_H)) : lfsr[9:5];

endmodule

// File: rtl/snake_game_core.sv
// rtl/snake_game_core.sv - snake body, movement tick, collisions and game FSM; SNAKE_WRAP_EN wraps walls
module snake_game_core
    import snake_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter logic [9:0]  LFSR_SEED   = 10'h2A5
) (
    input  logic              clk,
    input  logic              clrn,
    snake_game_core_if.slave  bus
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

    game_state_e                  state;
    dir_e                         dir_cur;
    dir_e                         dir_pend;
    logic [NUM_SEGS-1:0][4:0]     seg_x;
    logic [NUM_SEGS-1:0][4:0]     seg_y;
    logic [5:0]                   length;
    logic [4:0]                   apple_x;
    logic [4:0]                   apple_y;
    logic [CNT_W-1:0]             tick_cnt;

    logic [4:0]                   cand_x;
    logic [4:0]                   cand_y;
    logic [4:0]                   next_x;
    logic [4:0]                   next_y;
    logic                         wall_hit;
    logic                         wall_kill;
    logic                         eat;
    logic [5:0]                   check_len;
    logic [NUM_SEGS-1:0]          body_hit;
    logic                         self_hit;

    apple_lfsr #(.LFSR_SEED(LFSR_SEED)) u_apple_lfsr (
        .clk    (clk),
        .clrn   (clrn),
        .cand_x (cand_x),
        .cand_y (cand_y)
    );

    // Next head is always computed wrapped; wall_hit says whether a wall was crossed.
    always_comb begin
        next_x   = seg_x[0];
        next_y   = seg_y[0];
        wall_hit = 1'b0;
        case (dir_pend)
            DIR_UP: begin
                wall_hit = (seg_y[0] == 5'd0);
                next_y   = wall_hit ? 5'(GRID_H - 1) : seg_y[0] - 5'd1;
            end
            DIR_DOWN: begin
                wall_hit = (seg_y[0] == 5'(GRID_H - 1));
                next_y   = wall_hit ? 5'd0 : seg_y[0] + 5'd1;
            end
            DIR_RIGHT: begin
                wall_hit = (seg_x[0] == 5'(GRID_W - 1));
                next_x   = seg_x[0] + 5'd1;
            end
            default: begin
                wall_hit = (seg_x[0] == 5'd0);
                next_x   = seg_x[0] - 5'd1;
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_kill = 1'b0;
`else
    assign wall_kill = wall_hit;
`endif

    assign eat = (next_x == apple_x) && (next_y == apple_y);

    // The tail only counts as an obstacle when eating, since it does not vacate then.
    assign check_len = eat ? length : length - 6'd1;

    always_comb begin
        body_hit = '0;
        for (int i = 0; i < NUM_SEGS; i++) begin
            body_hit[i] = (seg_x[i] == next_x) && (seg_y[i] == next_y) && (6'(i) < check_len);
        end
    end

    assign self_hit = |body_hit;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= ST_INITIAL;
            dir_cur  <= DIR_RIGHT;
            dir_pend <= DIR_RIGHT;
            seg_x    <= INIT_SEG_X;
            seg_y    <= INIT_SEG_Y;
            length   <= INIT_LEN;
            apple_x  <= INIT_APPLE_X;
            apple_y  <= INIT_APPLE_Y;
            tick_cnt <= '0;
        end else begin
            if (bus.dir_valid && !is_reverse(bus.dir_in, dir_cur)) begin
                dir_pend <= dir_e'(bus.dir_in);
            end
            case (state)
                ST_INITIAL: begin
                    if (bus.start) begin
                        state    <= ST_RUNNING;
                        tick_cnt <= '0;
                    end
                end
                ST_RUNNING: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        dir_cur  <= dir_pend;
                        if (wall_kill || self_hit) begin
                            state <= ST_DIE;
                        end else begin
                            seg_x <= {seg_x[NUM_SEGS-2:0], next_x};
                            seg_y <= {seg_y[NUM_SEGS-2:0], next_y};
                            if (eat) begin
                                if (length != 6'(MAX_LEN)) begin
                                    length <= length + 6'd1;
                                end
                                apple_x <= cand_x;
                                apple_y <= cand_y;
                            end
                        end
                    end else begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_DIE: begin
                    // Restart reloads everything except the LFSR, which keeps running.
                    if (bus.start) begin
                        state    <= ST_INITIAL;
                        dir_cur  <= DIR_RIGHT;
                        dir_pend <= DIR_RIGHT;
                        seg_x    <= INIT_SEG_X;
                        seg_y    <= INIT_SEG_Y;
                        length   <= INIT_LEN;
                        apple_x  <= INIT_APPLE_X;
                        apple_y  <= INIT_APPLE_Y;
                        tick_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_INITIAL;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.snake_x_1dim = seg_x;
    assign bus.snake_y_1dim = seg_y;
    assign bus.snake_length = length;
    assign bus.apple_x      = apple_x;
    assign bus.apple_y      = apple_y;
    assign bus.game_state   = state;

endmodule
